// File: rtl/gpu_pkg.sv
// Shared GPU definitions: screen geometry, coefficient widths, setup FSM
// states and reject codes, plus small helpers for the triangle setup path.
package gpu_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  localparam int unsigned AB_W   = 9;
  localparam int unsigned C_W    = 18;
  localparam int unsigned AREA_W = 20;

  typedef enum logic [1:0] {
    REJ_NONE  = 2'd0,
    REJ_DEGEN = 2'd1,
    REJ_RANGE = 2'd2,
    REJ_BACK  = 2'd3
  } reject_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_MUL,
    S_CONST,
    S_CHECK,
    S_ISSUE,
    S_WAIT
  } setup_state_e;

  function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] c);
    logic [8:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] c);
    logic [8:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // b is carried one bit wider than the output so spans beyond 255 are detectable
  function automatic logic too_wide(input logic signed [AB_W:0] b);
    return (b > 10'sd255) || (b < -10'sd255);
  endfunction

endpackage

// File: rtl/edge_setup.sv
// One edge equation Vi->Vj: a = yi-yj, b = xj-xi (one bit wider than the output),
// c = xi*yj - xj*yi, built over the DIFF, MUL and CONST steps of the setup FSM.
module edge_setup
  import gpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en_diff,
  input  logic                  i_en_mul,
  input  logic                  i_en_const,
  input  logic [8:0]            i_xi,
  input  logic [7:0]            i_yi,
  input  logic [8:0]            i_xj,
  input  logic [7:0]            i_yj,
  output logic signed [AB_W-1:0] o_a,
  output logic signed [AB_W:0]   o_b,
  output logic signed [C_W-1:0]  o_c
);

  logic signed [AB_W-1:0] r_a;
  logic signed [AB_W:0]   r_b;
  logic signed [C_W-1:0]  r_c;
  logic [16:0]            r_p_ij;
  logic [16:0]            r_p_ji;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_p_ij <= '0;
      r_p_ji <= '0;
    end else begin
      if (i_en_diff) begin
        r_a <= $signed({1'b0, i_yi}) - $signed({1'b0, i_yj});
        r_b <= $signed({1'b0, i_xj}) - $signed({1'b0, i_xi});
      end
      if (i_en_mul) begin
        r_p_ij <= 17'(i_xi) * 17'(i_yj);
        r_p_ji <= 17'(i_xj) * 17'(i_yi);
      end
      if (i_en_const) begin
        r_c <= $signed({1'b0, r_p_ij}) - $signed({1'b0, r_p_ji});
      end
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;
  assign o_c = r_c;

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: latches one triangle, derives edge equations and bounding box,
// filters unusable triangles, then hands the rest to the rasterizer and waits.
module tri_setup
  import gpu_pkg::*;
#(
  parameter bit CULL_BACKFACE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tri_valid,
  output logic                   tri_ready,
  input  logic [8:0]             x1,
  input  logic [8:0]             x2,
  input  logic [8:0]             x3,
  input  logic [7:0]             y1,
  input  logic [7:0]             y2,
  input  logic [7:0]             y3,
  input  logic [15:0]            z1_in,
  input  logic [15:0]            z2_in,
  input  logic [15:0]            z3_in,
  input  logic [7:0]             color_in,
  input  logic [31:0]            inv_area_in,
  output logic signed [AB_W-1:0] a1,
  output logic signed [AB_W-1:0] b1,
  output logic signed [AB_W-1:0] a2,
  output logic signed [AB_W-1:0] b2,
  output logic signed [AB_W-1:0] a3,
  output logic signed [AB_W-1:0] b3,
  output logic signed [C_W-1:0]  c1,
  output logic signed [C_W-1:0]  c2,
  output logic signed [C_W-1:0]  c3,
  output logic [8:0]             bbxi,
  output logic [8:0]             bbxf,
  output logic [7:0]             bbyi,
  output logic [7:0]             bbyf,
  output logic [15:0]            z1,
  output logic [15:0]            z2,
  output logic [15:0]            z3,
  output logic [7:0]             color,
  output logic [31:0]            inv_area,
  output logic                   rasterizer_start,
  input  logic                   rasterizer_done,
  output logic [1:0]             reject_code,
  output logic [15:0]            drawn_count,
  output logic [15:0]            rejected_count
);

  setup_state_e r_state, w_next;
  reject_e      r_reject, w_code;

  logic [8:0] r_x1, r_x2, r_x3;
  logic [7:0] r_y1, r_y2, r_y3;

  logic signed [AB_W-1:0]   w_a1, w_a2, w_a3;
  logic signed [AB_W:0]     w_b1, w_b2, w_b3;
  logic signed [AB_W-1:0]   w_b1_t, w_b2_t, w_b3_t;
  logic signed [C_W-1:0]    w_c1, w_c2, w_c3;
  logic signed [AREA_W-1:0] w_area2;
  logic                     w_out_range, w_wide, w_flip;

  edge_setup u_e1 (
    .clk(clk), .rst(rst),
    .i_en_diff(r_state == S_DIFF), .i_en_mul(r_state == S_MUL), .i_en_const(r_state == S_CONST),
    .i_xi(r_x2), .i_yi(r_y2), .i_xj(r_x3), .i_yj(r_y3),
    .o_a(w_a1), .o_b(w_b1), .o_c(w_c1)
  );

  edge_setup u_e2 (
    .clk(clk), .rst(rst),
    .i_en_diff(r_state == S_DIFF), .i_en_mul(r_state == S_MUL), .i_en_const(r_state == S_CONST),
    .i_xi(r_x3), .i_yi(r_y3), .i_xj(r_x1), .i_yj(r_y1),
    .o_a(w_a2), .o_b(w_b2), .o_c(w_c2)
  );

  edge_setup u_e3 (
    .clk(clk), .rst(rst),
    .i_en_diff(r_state == S_DIFF), .i_en_mul(r_state == S_MUL), .i_en_const(r_state == S_CONST),
    .i_xi(r_x1), .i_yi(r_y1), .i_xj(r_x2), .i_yj(r_y2),
    .o_a(w_a3), .o_b(w_b3), .o_c(w_c3)
  );

  assign w_area2 = {{2{w_c1[C_W-1]}}, w_c1} + {{2{w_c2[C_W-1]}}, w_c2}
                 + {{2{w_c3[C_W-1]}}, w_c3};

  assign w_out_range = (r_x1 >= 9'(SCREEN_W)) || (r_x2 >= 9'(SCREEN_W)) ||
                       (r_x3 >= 9'(SCREEN_W)) || (r_y1 >= 8'(SCREEN_H)) ||
                       (r_y2 >= 8'(SCREEN_H)) || (r_y3 >= 8'(SCREEN_H));
  assign w_wide      = too_wide(w_b1) || too_wide(w_b2) || too_wide(w_b3);
  assign w_flip      = !CULL_BACKFACE && (w_area2 < 0);

  assign w_b1_t = w_b1[AB_W-1:0];
  assign w_b2_t = w_b2[AB_W-1:0];
  assign w_b3_t = w_b3[AB_W-1:0];

  always_comb begin
    w_code = REJ_NONE;
    if (w_out_range || w_wide)             w_code = REJ_RANGE;
    else if (w_area2 == '0)                w_code = REJ_DEGEN;
    else if (CULL_BACKFACE && w_area2 < 0) w_code = REJ_BACK;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    tri_ready        = 1'b0;
    rasterizer_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        tri_ready = 1'b1;
        if (tri_valid) w_next = S_DIFF;
      end
      S_DIFF:  w_next = S_MUL;
      S_MUL:   w_next = S_CONST;
      S_CONST: w_next = S_CHECK;
      S_CHECK: w_next = (w_code == REJ_NONE) ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        rasterizer_start = 1'b1;
        w_next           = S_WAIT;
      end
      S_WAIT:  if (rasterizer_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_x1, r_x2, r_x3, r_y1, r_y2, r_y3} <= '0;
      {a1, b1, a2, b2, a3, b3}             <= '0;
      {c1, c2, c3}                         <= '0;
      {bbxi, bbxf, bbyi, bbyf}             <= '0;
      {z1, z2, z3, color, inv_area}        <= '0;
      r_reject       <= REJ_NONE;
      drawn_count    <= '0;
      rejected_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (tri_valid) begin
          r_x1 <= x1; r_x2 <= x2; r_x3 <= x3;
          r_y1 <= y1; r_y2 <= y2; r_y3 <= y3;
          z1 <= z1_in; z2 <= z2_in; z3 <= z3_in;
          color    <= color_in;
          inv_area <= inv_area_in;
        end
        S_DIFF: begin
          bbxi <= min3(r_x1, r_x2, r_x3);
          bbxf <= max3(r_x1, r_x2, r_x3);
          bbyi <= 8'(min3({1'b0, r_y1}, {1'b0, r_y2}, {1'b0, r_y3}));
          bbyf <= 8'(max3({1'b0, r_y1}, {1'b0, r_y2}, {1'b0, r_y3}));
        end
        S_CHECK: begin
          // Clockwise triangles are redrawn by reversing every edge's sign
          a1 <= w_flip ? -w_a1 : w_a1;
          a2 <= w_flip ? -w_a2 : w_a2;
          a3 <= w_flip ? -w_a3 : w_a3;
          b1 <= w_flip ? -w_b1_t : w_b1_t;
          b2 <= w_flip ? -w_b2_t : w_b2_t;
          b3 <= w_flip ? -w_b3_t : w_b3_t;
          c1 <= w_flip ? -w_c1 : w_c1;
          c2 <= w_flip ? -w_c2 : w_c2;
          c3 <= w_flip ? -w_c3 : w_c3;
          r_reject <= w_code;
          if (w_code != REJ_NONE) rejected_count <= rejected_count + 16'd1;
        end
        S_WAIT: if (rasterizer_done) drawn_count <= drawn_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign reject_code = r_reject;

endmodule

// File: tb/tb_tri_setup.sv
// Directed bench for tri_setup: one culling and one non-culling instance share
// the same stimulus; expected coefficients, codes and counts are hand-computed.
module tb_tri_setup;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tri_valid, rasterizer_done;
  logic [8:0]  x1, x2, x3;
  logic [7:0]  y1, y2, y3;
  logic [15:0] z1_in, z2_in, z3_in;
  logic [7:0]  color_in;
  logic [31:0] inv_area_in;

  logic               c_ready, c_start;
  logic signed [8:0]  c_a1, c_b1, c_a2, c_b2, c_a3, c_b3;
  logic signed [17:0] c_c1, c_c2, c_c3;
  logic [8:0]         c_bbxi, c_bbxf;
  logic [7:0]         c_bbyi, c_bbyf, c_color;
  logic [15:0]        c_z1, c_z2, c_z3, c_drawn, c_rej;
  logic [31:0]        c_inv;
  logic [1:0]         c_code;

  logic               n_ready, n_start;
  logic signed [8:0]  n_a1, n_b1, n_a2, n_b2, n_a3, n_b3;
  logic signed [17:0] n_c1, n_c2, n_c3;
  logic [8:0]         n_bbxi, n_bbxf;
  logic [7:0]         n_bbyi, n_bbyf, n_color;
  logic [15:0]        n_z1, n_z2, n_z3, n_drawn, n_rej;
  logic [31:0]        n_inv;
  logic [1:0]         n_code;

  tri_setup #(.CULL_BACKFACE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(c_ready),
    .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3),
    .z1_in(z1_in), .z2_in(z2_in), .z3_in(z3_in), .color_in(color_in), .inv_area_in(inv_area_in),
    .a1(c_a1), .b1(c_b1), .a2(c_a2), .b2(c_b2), .a3(c_a3), .b3(c_b3),
    .c1(c_c1), .c2(c_c2), .c3(c_c3),
    .bbxi(c_bbxi), .bbxf(c_bbxf), .bbyi(c_bbyi), .bbyf(c_bbyf),
    .z1(c_z1), .z2(c_z2), .z3(c_z3), .color(c_color), .inv_area(c_inv),
    .rasterizer_start(c_start), .rasterizer_done(rasterizer_done),
    .reject_code(c_code), .drawn_count(c_drawn), .rejected_count(c_rej)
  );

  tri_setup #(.CULL_BACKFACE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(n_ready),
    .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3),
    .z1_in(z1_in), .z2_in(z2_in), .z3_in(z3_in), .color_in(color_in), .inv_area_in(inv_area_in),
    .a1(n_a1), .b1(n_b1), .a2(n_a2), .b2(n_b2), .a3(n_a3), .b3(n_b3),
    .c1(n_c1), .c2(n_c2), .c3(n_c3),
    .bbxi(n_bbxi), .bbxf(n_bbxf), .bbyi(n_bbyi), .bbyf(n_bbyf),
    .z1(n_z1), .z2(n_z2), .z3(n_z3), .color(n_color), .inv_area(n_inv),
    .rasterizer_start(n_start), .rasterizer_done(rasterizer_done),
    .reject_code(n_code), .drawn_count(n_drawn), .rejected_count(n_rej)
  );

  typedef struct {
    logic [8:0]         x1, x2, x3;
    logic [7:0]         y1, y2, y3;
    logic [1:0]         code_c, code_n;
    logic signed [8:0]  a1, b1, a2, b2, a3, b3;
    logic signed [17:0] c1, c2, c3;
    logic [8:0]         bxi, bxf;
    logic [7:0]         byi, byf;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   e_dc = 0, e_rc = 0, e_dn = 0, e_rn = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    x1 = v.x1; x2 = v.x2; x3 = v.x3;
    y1 = v.y1; y2 = v.y2; y3 = v.y3;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_drawn_c"}, c_drawn, e_dc);
    chk({tag, "_rej_c"},   c_rej,   e_rc);
    chk({tag, "_drawn_n"}, n_drawn, e_dn);
    chk({tag, "_rej_n"},   n_rej,   e_rn);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    drive(v);
    tri_valid = 1'b1;
    tick();
    tri_valid = 1'b0;
    chk({t, "_ready_T1"}, n_ready, 0);
    repeat (3) tick();
    chk({t, "_start_T4"}, n_start, 0);
    tick();
    chk({t, "_start_c"}, c_start, v.code_c == 2'd0);
    chk({t, "_start_n"}, n_start, v.code_n == 2'd0);
    chk({t, "_code_c"},  c_code,  v.code_c);
    chk({t, "_code_n"},  n_code,  v.code_n);
    chk({t, "_ready_c"}, c_ready, v.code_c != 2'd0);
    if (v.code_c != 2'd0) e_rc++;
    if (v.code_n != 2'd0) e_rn++;
    if (v.code_n == 2'd0) begin
      chk({t, "_a1"}, n_a1, v.a1); chk({t, "_b1"}, n_b1, v.b1); chk({t, "_c1"}, n_c1, v.c1);
      chk({t, "_a2"}, n_a2, v.a2); chk({t, "_b2"}, n_b2, v.b2); chk({t, "_c2"}, n_c2, v.c2);
      chk({t, "_a3"}, n_a3, v.a3); chk({t, "_b3"}, n_b3, v.b3); chk({t, "_c3"}, n_c3, v.c3);
      chk({t, "_bbxi"}, n_bbxi, v.bxi); chk({t, "_bbxf"}, n_bbxf, v.bxf);
      chk({t, "_bbyi"}, n_bbyi, v.byi); chk({t, "_bbyf"}, n_bbyf, v.byf);
      chk({t, "_z2"}, n_z2, 32'h5678); chk({t, "_inv"}, n_inv, 32'hdeadbeef);
    end
    if (v.code_c == 2'd0) begin
      chk({t, "_c_a1"}, c_a1, v.a1);
      chk({t, "_c_c3"}, c_c3, v.c3);
    end
    if (v.code_c == 2'd0 || v.code_n == 2'd0) begin
      repeat (3) tick();
      chk({t, "_start_wait"}, n_start, 0);
      chk({t, "_c1_held"}, n_c1, v.c1);
      rasterizer_done = 1'b1;
      tick();
      rasterizer_done = 1'b0;
      if (v.code_c == 2'd0) e_dc++;
      if (v.code_n == 2'd0) e_dn++;
      chk({t, "_ready_after_c"}, c_ready, 1);
      chk({t, "_ready_after_n"}, n_ready, 1);
    end
    chk_counts(t);
  endtask

  initial begin
    vecs[0] = '{x1:10, y1:10, x2:50, y2:10, x3:10, y3:50, code_c:0, code_n:0,
                a1:-40, b1:-40, c1:2400, a2:40, b2:0, c2:-400, a3:0, b3:40, c3:-400,
                bxi:10, bxf:50, byi:10, byf:50};
    vecs[1] = '{x1:10, y1:10, x2:10, y2:50, x3:50, y3:10, code_c:3, code_n:0,
                a1:-40, b1:-40, c1:2400, a2:0, b2:40, c2:-400, a3:40, b3:0, c3:-400,
                bxi:10, bxf:50, byi:10, byf:50};
    vecs[2] = '{x1:0, y1:0, x2:10, y2:10, x3:20, y3:20, code_c:1, code_n:1,
                a1:0, b1:0, c1:0, a2:0, b2:0, c2:0, a3:0, b3:0, c3:0,
                bxi:0, bxf:0, byi:0, byf:0};
    vecs[3] = '{x1:0, y1:0, x2:300, y2:0, x3:0, y3:10, code_c:2, code_n:2,
                a1:0, b1:0, c1:0, a2:0, b2:0, c2:0, a3:0, b3:0, c3:0,
                bxi:0, bxf:0, byi:0, byf:0};
    vecs[4] = '{x1:320, y1:10, x2:50, y2:10, x3:10, y3:50, code_c:2, code_n:2,
                a1:0, b1:0, c1:0, a2:0, b2:0, c2:0, a3:0, b3:0, c3:0,
                bxi:0, bxf:0, byi:0, byf:0};
    vecs[5] = '{x1:319, y1:239, x2:64, y2:239, x3:319, y3:0, code_c:0, code_n:0,
                a1:239, b1:255, c1:-76241, a2:-239, b2:0, c2:76241, a3:0, b3:-255, c3:60945,
                bxi:64, bxf:319, byi:0, byf:239};

    rst = 1'b1; tri_valid = 1'b0; rasterizer_done = 1'b0;
    x1 = '0; x2 = '0; x3 = '0; y1 = '0; y2 = '0; y3 = '0;
    z1_in = 16'h1234; z2_in = 16'h5678; z3_in = 16'h9abc;
    color_in = 8'h5a; inv_area_in = 32'hdeadbeef;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ready", c_ready, 1);
    chk("rst_start", c_start, 0);
    chk("rst_a1", c_a1, 0);
    chk("rst_c1", c_c1, 0);
    chk("rst_code", c_code, 0);
    chk("rst_inv", c_inv, 0);
    chk_counts("rst");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // tri_valid held through a long WAIT: no second accept until done
    begin
      bit ok;
      drive(vecs[0]);
      tri_valid = 1'b1;
      repeat (5) tick();
      chk("hold_start", c_start, 1);
      ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (c_start || c_ready || n_start || n_ready) ok = 1'b0;
      end
      chk("hold_no_reaccept", ok, 1);
      rasterizer_done = 1'b1;
      tri_valid = 1'b0;
      tick();
      rasterizer_done = 1'b0;
      e_dc++; e_dn++;
      chk("hold_ready", c_ready, 1);
      chk_counts("hold");
    end

    // done while idle is ignored
    rasterizer_done = 1'b1;
    tick();
    rasterizer_done = 1'b0;
    tick();
    chk("spur_ready", c_ready, 1);
    chk("spur_start", c_start, 0);
    chk_counts("spur");

    // reset in WAIT
    drive(vecs[0]);
    tri_valid = 1'b1;
    tick();
    tri_valid = 1'b0;
    repeat (6) tick();
    chk("wait_ready", c_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e_dc = 0; e_rc = 0; e_dn = 0; e_rn = 0;
    chk("arst_ready", c_ready, 1);
    chk("arst_start", n_start, 0);
    chk("arst_a1", c_a1, 0);
    chk("arst_c1", n_c1, 0);
    chk("arst_bbxf", c_bbxf, 0);
    chk("arst_z1", c_z1, 0);
    chk("arst_color", n_color, 0);
    chk("arst_inv", c_inv, 0);
    chk("arst_code", c_code, 0);
    chk_counts("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
